// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Holds the PC, issues word reads to a
//               one-cycle-latency instruction memory, buffers returned words
//               in a 2-entry FIFO and hands them to the decoder over a
//               valid/ready handshake. A redirect pulse flushes everything
//               buffered or in flight and restarts fetch at the new PC.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4
);

    localparam logic [1:0] c_FIFO_DEPTH = 2'd2;

    // Program counter and in-flight request tracking
    logic [31:0] r_fetch_pc;
    logic        r_pending;
    logic [31:0] r_pend_pc;

    // Two-entry FIFO of {instr, pc}
    logic [31:0] r_fifo_instr [2];
    logic [31:0] r_fifo_pc    [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic [31:0] w_redir_pc;
    logic [1:0]  w_credit;
    logic        w_push;
    logic        w_pop;

    // Redirect target forced word-aligned; masking keeps every input bit in use
    assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

    // Words already owed to the FIFO: buffered plus the one in flight
    assign w_credit = r_count + {1'b0, r_pending};

    // Response is only kept if no redirect squashes it this cycle
    assign w_push = r_pending && !redirect_valid;
    assign w_pop  = out_valid && out_ready;

    // Request/address selection and decoder-side outputs
    always_comb begin
        imem_addr = redirect_valid ? w_redir_pc : r_fetch_pc;
        out_valid = rst_n && (r_count != 2'd0) && !redirect_valid;
        imem_req  = rst_n && (redirect_valid || (w_credit < c_FIFO_DEPTH) ||
                              (out_valid && out_ready));
        out_instr = r_fifo_instr[r_rd_ptr];
        out_pc    = r_fifo_pc[r_rd_ptr];
        out_pc4   = r_fifo_pc[r_rd_ptr] + 32'd4;
    end

    // PC, pending-request and FIFO occupancy state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_pending  <= 1'b0;
            r_pend_pc  <= RESET_PC;
            r_count    <= 2'd0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
        end else begin
            if (imem_req) begin
                r_fetch_pc <= imem_addr + 32'd4;
            end
            r_pending <= imem_req;
            r_pend_pc <= imem_addr;
            if (redirect_valid) begin
                r_count  <= 2'd0;
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
            r_fifo_pc[r_wr_ptr]    <= r_pend_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch. A queue-based model of
//               the fetch stream is checked every cycle, and directed
//               scenarios pin specific literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;

    int n_cmp;
    int n_err;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc4        (out_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: word[i] = 0x13 + (i << 20)
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = {2'b00, a[31:2]};
        return 32'h0000_0013 + (idx << 20);
    endfunction

    // Synchronous instruction memory, one-cycle read latency
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_buf[$];   // words the decoder will see, oldest first
    logic [31:0] m_fly[$];   // address requested last cycle (0 or 1 entry)
    logic [31:0] m_nxt;
    logic        m_known;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_addr;

    initial m_known = 1'b0;

    // Compare process: inputs are stable from posedge+1, so check and advance here
    always @(negedge clk) begin
        e_valid = rst_n && (m_buf.size() != 0) && !redirect_valid;
        e_req   = rst_n && (redirect_valid || (m_buf.size() + m_fly.size() < 2) ||
                            (e_valid && out_ready));
        e_addr  = redirect_valid ? {redirect_pc[31:2], 2'b00} : m_nxt;
        chk("m_req", {31'd0, imem_req}, {31'd0, e_req});
        chk("m_valid", {31'd0, out_valid}, {31'd0, e_valid});
        if (m_known) chk("m_addr", imem_addr, e_addr);
        if (e_valid) begin
            chk("m_pc", out_pc, m_buf[0]);
            chk("m_instr", out_instr, mem_word(m_buf[0]));
            chk("m_pc4", out_pc4, m_buf[0] + 32'd4);
        end
        if (!rst_n) begin
            m_buf.delete();
            m_fly.delete();
            m_nxt   = 32'h0000_0000;
            m_known = 1'b1;
        end else begin
            if (e_valid && out_ready) void'(m_buf.pop_front());
            if (redirect_valid) m_buf.delete();
            else if (m_fly.size() != 0) m_buf.push_back(m_fly[0]);
            m_fly.delete();
            if (e_req) begin
                m_fly.push_back(e_addr);
                m_nxt = e_addr + 32'd4;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Advance one cycle and apply new inputs just after the edge
    task automatic step(input logic rn, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst_n          = rn;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, rdy, 1'b0, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;

        // Reset then stream
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'd0);            // cycle 0
        chk("c0_req", {31'd0, imem_req}, 32'd1);
        chk("c0_valid", {31'd0, out_valid}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);            // cycle 1
        chk("c1_valid", {31'd0, out_valid}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);            // cycle 2
        chk("c2_valid", {31'd0, out_valid}, 32'd1);
        chk("c2_pc", out_pc, 32'h0);
        chk("c2_instr", out_instr, 32'h0000_0013);
        chk("c2_pc4", out_pc4, 32'h4);
        step(1'b1, 1'b1, 1'b0, 32'd0);            // cycle 3
        chk("c3_pc", out_pc, 32'h4);
        chk("c3_instr", out_instr, 32'h0010_0013);
        run(4, 1'b1);

        // Backpressure for 5 cycles
        run(2, 1'b0);
        chk("bp_req", {31'd0, imem_req}, 32'd0);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        run(3, 1'b0);
        run(4, 1'b1);

        // Redirect while count = 1 and pending = 1
        step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        chk("rd_valid", {31'd0, out_valid}, 32'd0);
        chk("rd_addr", imem_addr, 32'h100);
        chk("rd_req", {31'd0, imem_req}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("rd1_valid", {31'd0, out_valid}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("rd2_pc", out_pc, 32'h100);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("rd3_pc", out_pc, 32'h104);
        run(2, 1'b1);

        // Redirect while stalled with a full FIFO
        run(3, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0203);
        chk("rs_addr", imem_addr, 32'h200);
        run(2, 1'b0);
        chk("rs_pc", out_pc, 32'h200);
        chk("rs_valid", {31'd0, out_valid}, 32'd1);
        run(3, 1'b1);

        // Reset mid-stream
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("mr_req", {31'd0, imem_req}, 32'd0);
        chk("mr_valid", {31'd0, out_valid}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("mr_addr", imem_addr, 32'h0);
        run(2, 1'b1);
        chk("mr_pc", out_pc, 32'h0);
        run(2, 1'b1);

        // Wrap-around
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        run(2, 1'b1);
        chk("wr_pc", out_pc, 32'hFFFF_FFFC);
        chk("wr_pc4", out_pc4, 32'h0);
        chk("wr_instr", out_instr, 32'hFFF0_0013);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("wr_next", out_pc, 32'h0);
        run(2, 1'b1);

        // Back-to-back redirects: the second wins
        step(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0080);
        run(2, 1'b1);
        chk("dr_pc", out_pc, 32'h80);

        // Mixed ready pattern, model-checked every cycle
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), (i % 13) == 7,
                 32'h0000_0400 + 32'($urandom_range(0, 63)));
        end
        run(4, 1'b1);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
